// File: rtl/svc_stream_serializer_if.sv
// Wide-word in / narrow-beat out stream bundle for svc_stream_serializer.
// slave modport is the serializer side; master is the driver/monitor side.
interface svc_stream_serializer_if #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_BEATS  = 4
);
  logic                             i_valid;
  logic                             o_ready;
  logic [DATA_WIDTH*NUM_BEATS-1:0]  i_data;
  logic                             o_valid;
  logic                             i_ready;
  logic [DATA_WIDTH-1:0]            o_data;
  logic                             o_last;

  modport slave (
    input  i_valid, i_data, i_ready,
    output o_ready, o_valid, o_data, o_last
  );

  modport master (
    output i_valid, i_data, i_ready,
    input  o_ready, o_valid, o_data, o_last
  );
endinterface

// File: rtl/svc_stream_serializer.sv
// Splits each DATA_WIDTH*NUM_BEATS word into NUM_BEATS beats; first beat one cycle after accept.
// Holds beat while i_ready low; takes a new word only when idle or on last-beat transfer. SVC_STREAM_SERIALIZER_MSB_FIRST_EN: MSB beat first.
module svc_stream_serializer #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_BEATS  = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  svc_stream_serializer_if.slave   bus
);
  localparam int            CW   = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1;
  localparam logic [CW-1:0] LAST = CW'(NUM_BEATS - 1);

  typedef enum logic {
    EMPTY = 1'b0,
    SEND  = 1'b1
  } state_t;

  state_t                          state_q, state_d;
  logic [CW-1:0]                   cnt_q, cnt_d;
  logic [DATA_WIDTH*NUM_BEATS-1:0] hold_q, hold_d;
  logic [CW-1:0]                   beat_sel;
  logic [DATA_WIDTH-1:0]           data_mux;
  logic                            valid_w;
  logic                            last_w;
  logic                            ready_w;
  logic                            accept;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= EMPTY;
      cnt_q   <= '0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hold_q  <= hold_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hold_d  = hold_q;
    valid_w = (state_q == SEND);
    last_w  = (state_q == SEND) && (cnt_q == LAST);
    ready_w = (state_q == EMPTY) || (last_w && bus.i_ready);
    accept  = bus.i_valid && ready_w;

    // A load on the last-beat edge overrides the return to EMPTY, so no bubble.
    if (accept) begin
      hold_d  = bus.i_data;
      cnt_d   = '0;
      state_d = SEND;
    end else if (valid_w && bus.i_ready) begin
      if (last_w) begin
        state_d = EMPTY;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

`ifdef SVC_STREAM_SERIALIZER_MSB_FIRST_EN
  assign beat_sel = LAST - cnt_q;
`else
  assign beat_sel = cnt_q;
`endif

  always_comb begin
    data_mux = '0;
    for (int b = 0; b < NUM_BEATS; b++) begin
      if (beat_sel == CW'(b)) begin
        data_mux = hold_q[b*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign bus.o_valid = valid_w;
  assign bus.o_last  = last_w;
  assign bus.o_ready = ready_w;
  assign bus.o_data  = data_mux;

endmodule

// File: tb/tb_svc_stream_serializer.sv
// Bench for svc_stream_serializer (8-bit beats, 4 beats/word): directed scenarios plus
// random traffic scored against a beat-queue model.
module tb_svc_stream_serializer;
  localparam int DW = 8;
  localparam int NB = 4;

  logic clk;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  svc_stream_serializer_if #(.DATA_WIDTH(DW), .NUM_BEATS(NB)) sif ();

  svc_stream_serializer #(.DATA_WIDTH(DW), .NUM_BEATS(NB)) dut (
    .clk (clk),
    .rst (rst),
    .bus (sif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [DW-1:0] beat_of(input logic [DW*NB-1:0] w, input int k);
`ifdef SVC_STREAM_SERIALIZER_MSB_FIRST_EN
    return w[(NB-1-k)*DW +: DW];
`else
    return w[k*DW +: DW];
`endif
  endfunction

  // Advance one edge, then apply inputs for the new cycle and let outputs settle.
  task automatic drive(input logic v, input logic [DW*NB-1:0] d, input logic r);
    @(posedge clk);
    #2;
    sif.i_valid = v;
    sif.i_data  = d;
    sif.i_ready = r;
    #1;
  endtask

  task automatic test_reset();
    logic [31:0] w;
    w = 32'h12345678;
    #3;
    checks++; if (sif.o_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got=%b exp=0", sif.o_valid); end
    checks++; if (sif.o_last !== 1'b0) begin errors++; $display("FAIL rst_last got=%b exp=0", sif.o_last); end
    checks++; if (sif.o_data !== 8'h00) begin errors++; $display("FAIL rst_data got=%h exp=00", sif.o_data); end
    checks++; if (sif.o_ready !== 1'b1) begin errors++; $display("FAIL rst_ready got=%b exp=1", sif.o_ready); end
    sif.i_valid = 1'b1;
    sif.i_data  = 32'hCAFEF00D;
    @(posedge clk);
    #2;
    checks++; if (sif.o_valid !== 1'b0) begin errors++; $display("FAIL rst_no_capture got=%b exp=0", sif.o_valid); end
    rst = 1'b0;
    sif.i_data  = w;
    sif.i_ready = 1'b1;
    for (int k = 0; k < NB; k++) begin
      drive(1'b0, '0, 1'b1);
      checks++;
      if (sif.o_valid !== 1'b1 || sif.o_data !== beat_of(w, k)) begin
        errors++; $display("FAIL post_rst_beat k=%0d got=%b/%h exp=1/%h", k, sif.o_valid, sif.o_data, beat_of(w, k));
      end
    end
    drive(1'b0, '0, 1'b1);
    checks++; if (sif.o_valid !== 1'b0) begin errors++; $display("FAIL post_rst_idle got=%b exp=0", sif.o_valid); end
  endtask

  task automatic test_basic();
    logic [31:0] w;
    w = 32'hDDCCBBAA;
    drive(1'b1, w, 1'b1);
    checks++;
    if (sif.o_valid !== 1'b0 || sif.o_ready !== 1'b1) begin
      errors++; $display("FAIL basic_idle got v=%b r=%b exp v=0 r=1", sif.o_valid, sif.o_ready);
    end
    for (int k = 0; k < NB; k++) begin
      drive(1'b0, '0, 1'b1);
      checks++;
      if (sif.o_valid !== 1'b1 || sif.o_data !== beat_of(w, k) || sif.o_last !== (k == NB-1) || sif.o_ready !== (k == NB-1)) begin
        errors++;
        $display("FAIL basic_beat k=%0d got v=%b d=%h l=%b r=%b exp v=1 d=%h l=%b r=%b",
                 k, sif.o_valid, sif.o_data, sif.o_last, sif.o_ready, beat_of(w, k), (k == NB-1), (k == NB-1));
      end
    end
    drive(1'b0, '0, 1'b1);
    checks++; if (sif.o_valid !== 1'b0) begin errors++; $display("FAIL basic_end got=%b exp=0", sif.o_valid); end
  endtask

  task automatic test_backpressure();
    logic [31:0] w;
    logic [DW-1:0] exp_d [0:6];
    logic          exp_l [0:6];
    logic          rdy   [0:6];
    w = 32'hDDCCBBAA;
    exp_d = '{beat_of(w,0), beat_of(w,1), beat_of(w,1), beat_of(w,1), beat_of(w,1), beat_of(w,2), beat_of(w,3)};
    exp_l = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    rdy   = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    drive(1'b1, w, 1'b1);
    for (int c = 0; c < 7; c++) begin
      drive(1'b0, '0, rdy[c]);
      checks++;
      if (sif.o_valid !== 1'b1 || sif.o_data !== exp_d[c] || sif.o_last !== exp_l[c] || sif.o_ready !== exp_l[c]) begin
        errors++;
        $display("FAIL bp_cycle c=%0d got v=%b d=%h l=%b r=%b exp v=1 d=%h l=%b r=%b",
                 c, sif.o_valid, sif.o_data, sif.o_last, sif.o_ready, exp_d[c], exp_l[c], exp_l[c]);
      end
    end
    drive(1'b0, '0, 1'b1);
    checks++; if (sif.o_valid !== 1'b0) begin errors++; $display("FAIL bp_end got=%b exp=0", sif.o_valid); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] w0, w1;
    logic [DW-1:0] e;
    w0 = 32'h03020100;
    w1 = 32'h07060504;
    drive(1'b1, w0, 1'b1);
    for (int k = 0; k < 2*NB; k++) begin
      drive(k < NB, (k < NB) ? w1 : 32'h0, 1'b1);
      e = (k < NB) ? beat_of(w0, k) : beat_of(w1, k - NB);
      checks++;
      if (sif.o_valid !== 1'b1 || sif.o_data !== e || sif.o_last !== (k % NB == NB-1) || sif.o_ready !== (k % NB == NB-1)) begin
        errors++;
        $display("FAIL b2b_beat k=%0d got v=%b d=%h l=%b r=%b exp d=%h l=%b", k, sif.o_valid, sif.o_data,
                 sif.o_last, sif.o_ready, e, (k % NB == NB-1));
      end
    end
    drive(1'b0, '0, 1'b1);
    checks++; if (sif.o_valid !== 1'b0) begin errors++; $display("FAIL b2b_end got=%b exp=0", sif.o_valid); end
  endtask

  task automatic test_reset_midword();
    drive(1'b1, 32'hDDCCBBAA, 1'b1);
    drive(1'b0, '0, 1'b1);
    drive(1'b0, '0, 1'b1);
    rst = 1'b1;
    #1;
    checks++;
    if (sif.o_valid !== 1'b0 || sif.o_last !== 1'b0 || sif.o_data !== 8'h00 || sif.o_ready !== 1'b1) begin
      errors++;
      $display("FAIL midrst_outputs got v=%b l=%b d=%h r=%b exp v=0 l=0 d=00 r=1", sif.o_valid, sif.o_last, sif.o_data, sif.o_ready);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 6; c++) begin
      drive(1'b0, '0, 1'b1);
      checks++; if (sif.o_valid !== 1'b0) begin errors++; $display("FAIL midrst_stale c=%0d got=%b exp=0", c, sif.o_valid); end
    end
  endtask

  task automatic test_busy_block();
    logic [31:0] w, b;
    w = 32'hDDCCBBAA;
    b = 32'h11111111;
    drive(1'b1, w, 1'b1);
    for (int k = 0; k < NB; k++) begin
      drive(1'b1, b, 1'b1);
      checks++;
      if (sif.o_data !== beat_of(w, k) || sif.o_ready !== (k == NB-1)) begin
        errors++; $display("FAIL busy_beat k=%0d got d=%h r=%b exp d=%h r=%b", k, sif.o_data, sif.o_ready, beat_of(w, k), (k == NB-1));
      end
    end
    for (int k = 0; k < NB; k++) begin
      drive(1'b0, '0, 1'b1);
      checks++;
      if (sif.o_valid !== 1'b1 || sif.o_data !== 8'h11 || sif.o_last !== (k == NB-1)) begin
        errors++; $display("FAIL busy_second k=%0d got v=%b d=%h l=%b exp v=1 d=11", k, sif.o_valid, sif.o_data, sif.o_last);
      end
    end
    drive(1'b0, '0, 1'b1);
    checks++; if (sif.o_valid !== 1'b0) begin errors++; $display("FAIL busy_no_dup got=%b exp=0", sif.o_valid); end
  endtask

  // Model: queue of beats still owed downstream. Only one word is ever in flight.
  task automatic test_random();
    logic [DW-1:0] q[$];
    logic          ev, el, er, v, r;
    logic [31:0]   d;
    int            words_in, beats_out;
    words_in = 0;
    beats_out = 0;
    for (int c = 0; c < 1500; c++) begin
      v = ($urandom_range(0, 99) < 55);
      r = ($urandom_range(0, 99) < 70);
      d = $urandom;
      drive(v, d, r);
      ev = (q.size() != 0);
      el = (q.size() == 1);
      er = (q.size() == 0) || (el && r);
      checks++;
      if (sif.o_valid !== ev || sif.o_last !== el || sif.o_ready !== er || (ev && sif.o_data !== q[0])) begin
        errors++;
        $display("FAIL rand_cycle c=%0d got v=%b l=%b r=%b d=%h exp v=%b l=%b r=%b d=%h", c, sif.o_valid, sif.o_last,
                 sif.o_ready, sif.o_data, ev, el, er, ev ? q[0] : 8'h00);
      end
      if (ev && r) begin
        void'(q.pop_front());
        beats_out++;
      end
      if (v && er) begin
        for (int k = 0; k < NB; k++) q.push_back(beat_of(d, k));
        words_in++;
      end
    end
    drive(1'b0, '0, 1'b1);
    while (q.size() != 0) begin
      checks++;
      if (sif.o_valid !== 1'b1 || sif.o_data !== q[0]) begin
        errors++; $display("FAIL rand_drain got v=%b d=%h exp v=1 d=%h", sif.o_valid, sif.o_data, q[0]);
      end
      void'(q.pop_front());
      beats_out++;
      drive(1'b0, '0, 1'b1);
    end
    checks++;
    if (sif.o_valid !== 1'b0 || beats_out != words_in*NB) begin
      errors++; $display("FAIL rand_totals got v=%b beats=%0d exp v=0 beats=%0d", sif.o_valid, beats_out, words_in*NB);
    end
  endtask

  initial begin
    rst         = 1'b1;
    sif.i_valid = 1'b0;
    sif.i_data  = '0;
    sif.i_ready = 1'b0;
    test_reset();
    test_basic();
    test_backpressure();
    test_back_to_back();
    test_reset_midword();
    test_busy_block();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
